shift_add_multiplier: RTL and testbench

//  Iterative unsigned multiplier built around the 8-bit ripple-carry adder datapath (fulladder chain).

---
 rtl/shift_add_multiplier.sv | 119 +++++++++++
 tb/tb_shift_add_multiplier.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier: one conditional add-and-shift per clock
// through a WIDTH-bit ripple-carry adder, with a single-cycle done pulse and a held product.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CW-1:0]      count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // Ripple-carry adder {C,S} = P + M built from full-adder cells, carry-in tied low.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = p_q[i] ^ m_q[i] ^ carry[i];
    assign carry[i+1] = (p_q[i] & m_q[i]) | (carry[i] & (p_q[i] ^ m_q[i]));
  end

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a_in;
          q_d     = b_in;
          p_d     = '0;
          count_d = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // The adder carry shifts into P's MSB, so no product bit is ever dropped.
        if (q_q[0]) begin
          {p_d, q_d} = {carry[WIDTH], sum, q_q[WIDTH-1:1]};
        end else begin
          {p_d, q_d} = {1'b0, p_q, q_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d   = DONE;
          product_d = {p_d, q_d};
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      q_q       <= q_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed corner cases plus random
// operands, checked against plain a*b arithmetic and the WIDTH+1 cycle latency rule.
module tb_shift_add_multiplier;

  localparam int WIDTH   = 8;
  localparam int LAT     = WIDTH + 1;
  localparam int PERIOD  = WIDTH + 2;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int n_cmp = 0;
  int n_err = 0;

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int unsigned ai;
    int unsigned bi;
    ai = a;
    bi = b;
    return ai * bi;
  endfunction

  // One complete operation: start pulse, then operands scrambled after acceptance.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    int cyc;
    bit seen;
    logic [31:0] exp;
    exp = ref_mul(a, b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in  = WIDTH'($urandom);
    b_in  = WIDTH'($urandom);
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 4 * LAT) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    check({tag, "_product"}, 32'(product), exp);
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_product_held"}, 32'(product), exp);
  endtask

  initial begin
    int pulses;
    int done_cyc[$];
    logic [31:0] seen_prod;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    rst = 1'b0;

    run_op(8'd3, 8'd5, "small");
    run_op(8'd255, 8'd255, "max");
    run_op(8'd0, 8'd200, "zero_a");
    run_op(8'd200, 8'd0, "zero_b");
    run_op(8'd128, 8'd2, "pow2");

    // Start pulsed mid-run must be ignored.
    @(negedge clk);
    a_in  = 8'd7;
    b_in  = 8'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_in  = 8'd1;
    b_in  = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    pulses    = 0;
    seen_prod = '0;
    repeat (3 * PERIOD) begin
      if (done) begin
        pulses++;
        seen_prod = 32'(product);
      end
      @(negedge clk);
    end
    check("ignore_pulses", 32'(pulses), 32'd1);
    check("ignore_product", seen_prod, ref_mul(8'd7, 8'd9));

    // Reset mid-run abandons the operation.
    @(negedge clk);
    a_in  = 8'd12;
    b_in  = 8'd12;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    pulses = 0;
    repeat (2 * PERIOD) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_op(8'd12, 8'd12, "restart");

    // rst and start together: rst wins.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 8'd9;
    b_in  = 8'd9;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_product", 32'(product), 32'd0);

    // Start held high: a new operation launches every PERIOD cycles.
    @(negedge clk);
    a_in  = 8'd10;
    b_in  = 8'd20;
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 3 * PERIOD; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cyc.push_back(cyc);
        check("held_product", 32'(product), ref_mul(8'd10, 8'd20));
      end
    end
    start = 1'b0;
    check("held_count", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() >= 2) begin
      check("held_first", 32'(done_cyc[0]), 32'(LAT));
      check("held_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'(PERIOD));
    end else begin
      check("held_pulses_present", 32'(done_cyc.size()), 32'd2);
    end
    repeat (PERIOD + 2) @(negedge clk);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 16; i++) begin
      run_op(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
